// File: rtl/dtw_stim_streamer.sv
`timescale 1ns/1ps
// Replays a memory-resident sample stream through a show-ahead FIFO read port, with optional periodic gaps.
// Optional sink statistics (count/sum/periodic full) are built only when STIM_SINK_CHECK_EN is defined.
module dtw_stim_streamer #(
   parameter int DWIDTH     = 16,
   parameter int AXI_DWIDTH = 32,
   parameter int AW         = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [AW-1:0]         base_addr,
   input  logic [31:0]           len,
   input  logic [7:0]            gap_period,
   input  logic [7:0]            gap_len,
   output logic                  busy,
   output logic                  done,
   input  logic                  mem_wren,
   input  logic [AW-1:0]         mem_waddr,
   input  logic [DWIDTH-1:0]     mem_wdata,
   input  logic                  src_fifo_rden,
   output logic                  src_fifo_empty,
   output logic [AXI_DWIDTH-1:0] src_fifo_data,
   input  logic                  sink_fifo_wren,
   input  logic [AXI_DWIDTH-1:0] sink_fifo_data,
   output logic                  sink_fifo_full,
   output logic [31:0]           sink_count,
   output logic [31:0]           sink_sum
);
   typedef enum logic [2:0] {S_IDLE, S_PREFETCH, S_STREAM, S_GAP, S_DONE} state_t;

   state_t            r_state;
   logic [DWIDTH-1:0] r_mem [2**AW];
   logic [DWIDTH-1:0] r_rd_dat;
   logic [AW-1:0]     r_addr;
   logic [31:0]       r_len;
   logic [31:0]       r_pop_cnt;
   logic [7:0]        r_gap_per;
   logic [7:0]        r_gap_len;
   logic [7:0]        r_gap_cnt;
   logic [7:0]        r_gap_tmr;
   logic              r_busy;
   logic              r_done;
   logic              r_empty;
   logic              w_pop;
   logic [AW-1:0]     w_raddr;

   // Reading the post-pop address every cycle keeps the next sample ready with no bubble.
   assign w_pop   = src_fifo_rden && !r_empty;
   assign w_raddr = w_pop ? r_addr + AW'(1) : r_addr;

   always_ff @(posedge clk) begin
      if (mem_wren)
         r_mem[mem_waddr] <= mem_wdata;
      r_rd_dat <= r_mem[w_raddr];
   end

   assign busy           = r_busy;
   assign done           = r_done;
   assign src_fifo_empty = r_empty;
   assign src_fifo_data  = r_empty ? '0 : AXI_DWIDTH'(r_rd_dat);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_empty   <= 1'b1;
         r_addr    <= '0;
         r_len     <= '0;
         r_pop_cnt <= '0;
         r_gap_per <= '0;
         r_gap_len <= '0;
         r_gap_cnt <= '0;
         r_gap_tmr <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_addr    <= base_addr;
                  r_len     <= len;
                  r_gap_per <= gap_period;
                  r_gap_len <= gap_len;
                  r_pop_cnt <= '0;
                  r_gap_cnt <= '0;
                  r_busy    <= 1'b1;
                  if (len == 32'd0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_PREFETCH;
                  end
               end
            end
            S_PREFETCH: begin
               r_state <= S_STREAM;
               r_empty <= 1'b0;
            end
            S_STREAM: begin
               if (w_pop) begin
                  r_addr    <= r_addr + AW'(1);
                  r_pop_cnt <= r_pop_cnt + 32'd1;
                  // The final pop wins over a gap that would fall due on the same sample.
                  if (r_pop_cnt + 32'd1 == r_len) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                     r_empty <= 1'b1;
                  end else if (r_gap_per != 8'd0 && r_gap_cnt + 8'd1 == r_gap_per) begin
                     r_state   <= S_GAP;
                     r_empty   <= 1'b1;
                     r_gap_cnt <= '0;
                     r_gap_tmr <= (r_gap_len == 8'd0) ? 8'd1 : r_gap_len;
                  end else begin
                     r_gap_cnt <= r_gap_cnt + 8'd1;
                  end
               end
            end
            S_GAP: begin
               if (r_gap_tmr <= 8'd1) begin
                  r_state <= S_STREAM;
                  r_empty <= 1'b0;
               end else begin
                  r_gap_tmr <= r_gap_tmr - 8'd1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef STIM_SINK_CHECK_EN
   logic        r_sink_full;
   logic [31:0] r_sink_cnt;
   logic [31:0] r_sink_sum;
   logic        w_sink_acc;

   assign w_sink_acc = sink_fifo_wren && !r_sink_full;

   // Full pulses for one cycle after every eighth accepted write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sink_full <= 1'b0;
         r_sink_cnt  <= '0;
         r_sink_sum  <= '0;
      end else begin
         r_sink_full <= w_sink_acc && (r_sink_cnt[2:0] == 3'd7);
         if (w_sink_acc) begin
            r_sink_cnt <= r_sink_cnt + 32'd1;
            r_sink_sum <= r_sink_sum + 32'(sink_fifo_data);
         end
      end
   end

   assign sink_fifo_full = r_sink_full;
   assign sink_count     = r_sink_cnt;
   assign sink_sum       = r_sink_sum;
`else
   logic w_unused_sink;
   assign w_unused_sink  = ^{sink_fifo_wren, sink_fifo_data};
   assign sink_fifo_full = 1'b0;
   assign sink_count     = '0;
   assign sink_sum       = '0;
`endif

endmodule

// File: tb/tb_dtw_stim_streamer.sv
`timescale 1ns/1ps
// Directed bench for dtw_stim_streamer: per-cycle expected stream tables, reset, wrap, gaps and sink stats.
module tb_dtw_stim_streamer;
   localparam int DW  = 16;
   localparam int ADW = 32;
   localparam int AW  = 15;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic [AW-1:0]  base_addr;
   logic [31:0]    len;
   logic [7:0]     gap_period;
   logic [7:0]     gap_len;
   logic           busy;
   logic           done;
   logic           mem_wren;
   logic [AW-1:0]  mem_waddr;
   logic [DW-1:0]  mem_wdata;
   logic           src_fifo_rden;
   logic           src_fifo_empty;
   logic [ADW-1:0] src_fifo_data;
   logic           sink_fifo_wren;
   logic [ADW-1:0] sink_fifo_data;
   logic           sink_fifo_full;
   logic [31:0]    sink_count;
   logic [31:0]    sink_sum;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dtw_stim_streamer #(.DWIDTH(DW), .AXI_DWIDTH(ADW), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
      .gap_period(gap_period), .gap_len(gap_len), .busy(busy), .done(done),
      .mem_wren(mem_wren), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .src_fifo_rden(src_fifo_rden), .src_fifo_empty(src_fifo_empty), .src_fifo_data(src_fifo_data),
      .sink_fifo_wren(sink_fifo_wren), .sink_fifo_data(sink_fifo_data), .sink_fifo_full(sink_fifo_full),
      .sink_count(sink_count), .sink_sum(sink_sum)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mem_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
      mem_wren  = 1'b1;
      mem_waddr = a;
      mem_wdata = d;
      tick();
      mem_wren  = 1'b0;
   endtask

   task automatic kick(input logic [AW-1:0] b, input logic [31:0] l, input logic [7:0] gp, input logic [7:0] gl);
      base_addr  = b;
      len        = l;
      gap_period = gp;
      gap_len    = gl;
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b want 0", busy); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %0b want 0", done); end
      n_vec++; if (src_fifo_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %0b want 1", src_fifo_empty); end
      n_vec++; if (src_fifo_data !== 32'd0) begin n_err++; $display("FAIL rst_data: got %0h want 0", src_fifo_data); end
      n_vec++; if (sink_fifo_full !== 1'b0) begin n_err++; $display("FAIL rst_full: got %0b want 0", sink_fifo_full); end
      n_vec++; if (sink_count !== 32'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", sink_count); end
      n_vec++; if (sink_sum !== 32'd0) begin n_err++; $display("FAIL rst_sum: got %0d want 0", sink_sum); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int e[7] = '{0, 1, 2, 3, 4, 0, 0};
      for (int i = 0; i < 4; i++) mem_load(AW'(i), DW'(i + 1));
      src_fifo_rden = 1'b1;
      kick('0, 32'd4, 8'd0, 8'd0);
      for (int i = 0; i < 7; i++) begin
         n_vec++;
         if (src_fifo_empty !== (e[i] == 0) || (e[i] != 0 && src_fifo_data !== 32'(e[i]))) begin
            n_err++; $display("FAIL basic cyc%0d: empty=%0b data=%0h want sample %0h", i, src_fifo_empty, src_fifo_data, e[i]);
         end
         n_vec++;
         if (done !== (i == 5) || busy !== (i <= 5)) begin
            n_err++; $display("FAIL basic_ctl cyc%0d: done=%0b busy=%0b want done=%0b busy=%0b", i, done, busy, i == 5, i <= 5);
         end
         tick();
      end
   endtask

   task automatic test_gap();
      int e[15] = '{0, 1, 2, 0, 0, 0, 3, 4, 0, 0, 0, 5, 6, 0, 0};
      mem_load(AW'(4), DW'(5));
      mem_load(AW'(5), DW'(6));
      src_fifo_rden = 1'b1;
      kick('0, 32'd6, 8'd2, 8'd3);
      for (int i = 0; i < 15; i++) begin
         n_vec++;
         if (src_fifo_empty !== (e[i] == 0) || (e[i] != 0 && src_fifo_data !== 32'(e[i]))) begin
            n_err++; $display("FAIL gap cyc%0d: empty=%0b data=%0h want sample %0h", i, src_fifo_empty, src_fifo_data, e[i]);
         end
         n_vec++;
         if (done !== (i == 13) || busy !== (i <= 13)) begin
            n_err++; $display("FAIL gap_ctl cyc%0d: done=%0b busy=%0b want done=%0b busy=%0b", i, done, busy, i == 13, i <= 13);
         end
         tick();
      end
   endtask

   task automatic test_wrap();
      int e[7] = '{0, 'hA, 'hB, 'hC, 'hD, 0, 0};
      mem_load(15'h7FFE, 16'hA);
      mem_load(15'h7FFF, 16'hB);
      mem_load(15'h0000, 16'hC);
      mem_load(15'h0001, 16'hD);
      src_fifo_rden = 1'b1;
      kick(15'h7FFE, 32'd4, 8'd0, 8'd0);
      for (int i = 0; i < 7; i++) begin
         n_vec++;
         if (src_fifo_empty !== (e[i] == 0) || (e[i] != 0 && src_fifo_data !== 32'(e[i]))) begin
            n_err++; $display("FAIL wrap cyc%0d: empty=%0b data=%0h want sample %0h", i, src_fifo_empty, src_fifo_data, e[i]);
         end
         n_vec++;
         if (done !== (i == 5)) begin
            n_err++; $display("FAIL wrap_done cyc%0d: got %0b want %0b", i, done, i == 5);
         end
         tick();
      end
   endtask

   task automatic test_stall();
      int  e[9] = '{0, 'h100, 'h100, 'h100, 'h101, 'h101, 'h102, 0, 0};
      bit  r[9] = '{1, 0, 0, 1, 0, 1, 1, 1, 1};
      for (int i = 0; i < 10; i++) mem_load(AW'(16 + i), DW'(256 + i));
      src_fifo_rden = 1'b0;
      kick(15'h0010, 32'd3, 8'd0, 8'd0);
      for (int i = 0; i < 9; i++) begin
         src_fifo_rden = r[i];
         n_vec++;
         if (src_fifo_empty !== (e[i] == 0) || (e[i] != 0 && src_fifo_data !== 32'(e[i]))) begin
            n_err++; $display("FAIL stall cyc%0d: empty=%0b data=%0h want sample %0h", i, src_fifo_empty, src_fifo_data, e[i]);
         end
         n_vec++;
         if (done !== (i == 7) || busy !== (i <= 7)) begin
            n_err++; $display("FAIL stall_ctl cyc%0d: done=%0b busy=%0b want done=%0b busy=%0b", i, done, busy, i == 7, i <= 7);
         end
         // A start while streaming must not restart or retarget the stream.
         if (i == 1) begin
            base_addr = 15'h0018;
            len       = 32'd5;
            start     = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
      end
   endtask

   task automatic test_midstream_reset();
      int e[13] = '{0, 'h100, 'h101, 'h102, 'h103, 'h104, 'h105, 'h106, 'h107, 'h108, 'h109, 0, 0};
      src_fifo_rden = 1'b1;
      kick(15'h0010, 32'd10, 8'd0, 8'd0);
      tick();
      tick();
      tick();
      n_vec++;
      if (src_fifo_empty !== 1'b0 || src_fifo_data !== 32'h102) begin
         n_err++; $display("FAIL pre_rst_sample3: empty=%0b data=%0h want 0/102", src_fifo_empty, src_fifo_data);
      end
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if (src_fifo_empty !== 1'b1 || busy !== 1'b0 || src_fifo_data !== 32'd0 || done !== 1'b0) begin
         n_err++; $display("FAIL async_rst: empty=%0b busy=%0b data=%0h done=%0b want 1/0/0/0", src_fifo_empty, busy, src_fifo_data, done);
      end
      #1 rst_n = 1'b1;
      tick();
      n_vec++;
      if (src_fifo_empty !== 1'b1 || busy !== 1'b0) begin
         n_err++; $display("FAIL post_rst_idle: empty=%0b busy=%0b want 1/0", src_fifo_empty, busy);
      end
      kick(15'h0010, 32'd10, 8'd0, 8'd0);
      for (int i = 0; i < 13; i++) begin
         n_vec++;
         if (src_fifo_empty !== (e[i] == 0) || (e[i] != 0 && src_fifo_data !== 32'(e[i]))) begin
            n_err++; $display("FAIL replay cyc%0d: empty=%0b data=%0h want sample %0h", i, src_fifo_empty, src_fifo_data, e[i]);
         end
         n_vec++;
         if (done !== (i == 11)) begin
            n_err++; $display("FAIL replay_done cyc%0d: got %0b want %0b", i, done, i == 11);
         end
         tick();
      end
   endtask

   task automatic test_len_zero();
      src_fifo_rden = 1'b1;
      kick('0, 32'd0, 8'd0, 8'd0);
      n_vec++;
      if (done !== 1'b1 || busy !== 1'b1 || src_fifo_empty !== 1'b1) begin
         n_err++; $display("FAIL len0_done: done=%0b busy=%0b empty=%0b want 1/1/1", done, busy, src_fifo_empty);
      end
      tick();
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0 || src_fifo_empty !== 1'b1) begin
         n_err++; $display("FAIL len0_after: done=%0b busy=%0b empty=%0b want 0/0/1", done, busy, src_fifo_empty);
      end
      tick();
      n_vec++;
      if (src_fifo_empty !== 1'b1 || src_fifo_data !== 32'd0) begin
         n_err++; $display("FAIL len0_idle: empty=%0b data=%0h want 1/0", src_fifo_empty, src_fifo_data);
      end
      src_fifo_rden = 1'b0;
   endtask

   task automatic test_sink();
      sink_fifo_data = 32'd5;
      sink_fifo_wren = 1'b1;
      for (int j = 1; j <= 10; j++) begin
         tick();
`ifdef STIM_SINK_CHECK_EN
         n_vec++;
         if (sink_fifo_full !== (j == 8)) begin
            n_err++; $display("FAIL sink_full wr%0d: got %0b want %0b", j, sink_fifo_full, j == 8);
         end
`else
         n_vec++;
         if (sink_fifo_full !== 1'b0 || sink_count !== 32'd0 || sink_sum !== 32'd0) begin
            n_err++; $display("FAIL sink_tied wr%0d: full=%0b count=%0d sum=%0d want 0/0/0", j, sink_fifo_full, sink_count, sink_sum);
         end
`endif
      end
      sink_fifo_wren = 1'b0;
      tick();
`ifdef STIM_SINK_CHECK_EN
      n_vec++;
      if (sink_count !== 32'd9) begin n_err++; $display("FAIL sink_count: got %0d want 9", sink_count); end
      n_vec++;
      if (sink_sum !== 32'd45) begin n_err++; $display("FAIL sink_sum: got %0d want 45", sink_sum); end
`else
      n_vec++;
      if (sink_count !== 32'd0 || sink_sum !== 32'd0) begin
         n_err++; $display("FAIL sink_stats_tied: count=%0d sum=%0d want 0/0", sink_count, sink_sum);
      end
`endif
   endtask

   initial begin
      rst_n          = 1'b0;
      start          = 1'b0;
      base_addr      = '0;
      len            = '0;
      gap_period     = '0;
      gap_len        = '0;
      mem_wren       = 1'b0;
      mem_waddr      = '0;
      mem_wdata      = '0;
      src_fifo_rden  = 1'b0;
      sink_fifo_wren = 1'b0;
      sink_fifo_data = '0;
      test_reset();
      test_basic();
      test_gap();
      test_wrap();
      test_stall();
      test_midstream_reset();
      test_len_zero();
      test_sink();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dtw_stim_streamer.md
DTW_STIM_STREAMER -- requirements
Module: dtw_stim_streamer

Interface
REQ-001 SHALL have parameter DWIDTH, default 16: sample width stored in memory.
REQ-002 SHALL have parameter AXI_DWIDTH, default 32: source/sink data width; DWIDTH <= AXI_DWIDTH.
REQ-003 SHALL have parameter AW, default 15: memory address width; depth 2^AW words.
REQ-004 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse, begins a stream when idle.
REQ-007 SHALL have port base_addr  in  AW  first memory address of the stream.
REQ-008 SHALL have port len  in  32  number of samples to stream.
REQ-009 SHALL have port gap_period  in  8  pops between injected gaps; 0 = no gaps.
REQ-010 SHALL have port gap_len  in  8  cycles src_fifo_empty is forced high per gap.
REQ-011 SHALL have port busy  out  1  high from accepted start until done.
REQ-012 SHALL have port done  out  1  one-cycle pulse after the last sample is popped.
REQ-013 SHALL have ports mem_wren in 1, mem_waddr in AW, mem_wdata in DWIDTH: memory load port.
REQ-014 SHALL have port src_fifo_rden  in  1  consumer pop.
REQ-015 SHALL have port src_fifo_empty  out  1  high when src_fifo_data is not valid.
REQ-016 SHALL have port src_fifo_data  out  AXI_DWIDTH  current sample, zero-extended.
REQ-017 SHALL have ports sink_fifo_wren in 1, sink_fifo_data in AXI_DWIDTH, sink_fifo_full out 1: result sink.
REQ-018 SHALL have ports sink_count out 32, sink_sum out 32: sink statistics.

Function
REQ-019 Memory SHALL be synchronous single-write/single-read, 1-cycle read latency; read-during-write to same address returns old data.
REQ-020 FSM SHALL have states IDLE, PREFETCH, STREAM, GAP, DONE.
REQ-021 IDLE: start with len>0 -> PREFETCH, latch base_addr/len/gap_period/gap_len; start with len=0 -> DONE; start outside IDLE ignored.
REQ-022 PREFETCH SHALL issue read of base_addr and enter STREAM after one cycle with first sample registered; src_fifo_empty high throughout PREFETCH.
REQ-023 Interface SHALL be show-ahead: in STREAM src_fifo_empty=0 and src_fifo_data valid; pop = src_fifo_rden & !src_fifo_empty.
REQ-024 Each pop SHALL present next sample on the following cycle with no bubble (prefetch register), sustaining one pop per cycle.
REQ-025 Read address SHALL wrap modulo 2^AW (base_addr + i).
REQ-026 src_fifo_rden while src_fifo_empty=1 SHALL be ignored and not advance address.
REQ-027 When gap_period!=0 and pop count since last gap reaches gap_period, FSM SHALL enter GAP for gap_len cycles (gap_len=0 treated as 1), then return to STREAM with data unchanged.
REQ-028 Popping sample len SHALL move to DONE, even if a gap would also be due; DONE pulses done for one cycle, then IDLE; src_fifo_empty=1 in DONE/IDLE.
REQ-029 busy SHALL be high in PREFETCH, STREAM, GAP, DONE.
REQ-030 Pop counter SHALL be 32 bits; len up to 2^32-1 supported.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, busy=0, done=0, src_fifo_empty=1, src_fifo_data=0, sink_fifo_full=0, sink_count=0, sink_sum=0, including mid-stream.
REQ-032 Memory contents SHALL not be cleared by reset.

Configuration
REQ-033 Macro STIM_SINK_CHECK_EN defined: each sink_fifo_wren with sink_fifo_full=0 increments sink_count and adds sink_fifo_data to sink_sum (mod 2^32); sink_fifo_full is asserted for one cycle after every 8th accepted write.
REQ-034 Macro undefined: sink logic absent; sink_fifo_full, sink_count, sink_sum tied to 0; sink inputs ignored.

Verification
REQ-035 Load mem[0..3]=1,2,3,4; base_addr=0, len=4, gap_period=0, rden held 1 -> data 1,2,3,4 on consecutive cycles, done pulse once, busy low after.
REQ-036 len=6, gap_period=2, gap_len=3, rden held 1 -> pairs of samples separated by 3 empty cycles; no gap after sample 6.
REQ-037 base_addr=0x7FFE, len=4, mem[0x7FFE,0x7FFF,0,1]=A,B,C,D -> A,B,C,D (wrap).
REQ-038 rst_n low at sample 3 of len=10 -> empty=1, busy=0 immediately; new start replays from base_addr.
REQ-039 start with len=0 -> done pulse one cycle later, no pop accepted, src_fifo_empty stays 1.
REQ-040 STIM_SINK_CHECK_EN defined, 10 sink writes of value 5, wren held -> full high one cycle after 8th write, 9th write in that cycle dropped, sink_count=9, sink_sum=45.
